// File: rtl/scrambler_pkg.sv
// scrambler_pkg: shared constants and the mode enum for the parallel
// x^7+x^4+1 scrambler/descrambler (scramble_par and scrambler_step).
package scrambler_pkg;
  localparam int LFSR_LEN    = 7;
  localparam int TAP_HI      = 6;   // x^7 term, oldest state bit
  localparam int TAP_LO      = 3;   // x^4 term
  localparam int SEED_BITS   = 7;
  localparam int SERVICE_LEN = 16;
  localparam int CNT_W       = 5;   // frame bit counter, saturates at SERVICE_LEN

  typedef enum logic {
    MODE_DESCRAMBLE = 1'b0,
    MODE_SCRAMBLE   = 1'b1
  } mode_e;
endpackage

// File: rtl/scrambler_step.sv
// scrambler_step: one combinational bit step of the x^7+x^4+1 LFSR.
//   state      : LFSR state before this bit
//   in         : input bit
//   init_phase : descrambler seed capture; load `in` into state[init_idx]
//   init_idx   : state bit receiving the captured bit
//   next_state : LFSR state after this bit
//   out        : processed bit (0 while capturing the seed)
module scrambler_step
  import scrambler_pkg::*;
(
  input  logic [LFSR_LEN-1:0] state,
  input  logic                in,
  input  logic                init_phase,
  input  logic [2:0]          init_idx,
  output logic [LFSR_LEN-1:0] next_state,
  output logic                out
);
  logic fb;

  always_comb begin
    fb         = state[TAP_HI] ^ state[TAP_LO];
    next_state = {state[LFSR_LEN-2:0], fb};
    out        = fb ^ in;
    if (init_phase) begin
      // Seed capture: the received bit is the scrambler state bit itself,
      // the plaintext here is the all-zero SERVICE[6:0].
      next_state           = state;
      next_state[init_idx] = in;
      out                  = 1'b0;
    end
  end
endmodule

// File: rtl/scramble_par.sv
// scramble_par: 802.11 scrambler/descrambler, DATA_W bits per beat (bit 0
// earliest). Descramble recovers the seed from the first 7 received bits;
// scramble runs from seed_in loaded on start. One cycle latency.
//   clock, reset (sync, active-high), enable (freezes everything when low)
//   start/mode/seed_in : frame start, mode and scramble seed (on start)
//   in_data/in_valid   -> out_data/out_valid
//   seed_out/seed_valid: recovered or loaded seed, valid level
//   service_err        : pulse if SERVICE[15:7] nonzero (descramble only)
// Build option: define SCRAMBLER_SERVICE_CHECK_EN to build the SERVICE
// reserved-bit check; otherwise service_err is tied low.
module scramble_par
  import scrambler_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 mode,
  input  logic [SEED_BITS-1:0] seed_in,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  output logic [SEED_BITS-1:0] seed_out,
  output logic                 seed_valid,
  output logic                 service_err
);
  logic [LFSR_LEN-1:0]  s_q, s_d, s_b;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_b;
  mode_e                mode_q, mode_d, mode_b;
  logic [DATA_W-1:0]    out_data_q, out_data_d, out_vec;
  logic                 out_valid_q, out_valid_d;
  logic [SEED_BITS-1:0] seed_out_q, seed_out_d, seed_out_b;
  logic                 seed_valid_q, seed_valid_d, seed_valid_b;
  logic [5:0]           cnt_sum;

  logic [LFSR_LEN-1:0]  chain_s   [DATA_W+1];
  logic                 out_bit   [DATA_W];
  logic [5:0]           bit_cnt_w [DATA_W];

  // Frame context as seen by this beat: a start in the same cycle applies first.
  always_comb begin
    mode_b       = mode_q;
    s_b          = s_q;
    cnt_b        = cnt_q;
    seed_out_b   = seed_out_q;
    seed_valid_b = seed_valid_q;
    if (start) begin
      mode_b = mode_e'(mode);
      cnt_b  = '0;
      if (mode_e'(mode) == MODE_SCRAMBLE) begin
        s_b          = seed_in;
        seed_out_b   = seed_in;
        seed_valid_b = 1'b1;
      end else begin
        s_b          = '0;
        seed_out_b   = '0;
        seed_valid_b = 1'b0;
      end
    end
  end

  assign chain_s[0] = s_b;

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    logic       init;
    logic [2:0] idx;
    assign bit_cnt_w[i] = {1'b0, cnt_b} + 6'(i);
    assign init = (mode_b == MODE_DESCRAMBLE) && (bit_cnt_w[i] < 6'(SEED_BITS));
    assign idx  = 3'(6'(LFSR_LEN-1) - bit_cnt_w[i]);
    scrambler_step u_step (
      .state      (chain_s[i]),
      .in         (in_data[i]),
      .init_phase (init),
      .init_idx   (idx),
      .next_state (chain_s[i+1]),
      .out        (out_bit[i])
    );
  end

  always_comb begin
    for (int i = 0; i < DATA_W; i++) out_vec[i] = out_bit[i];
  end

  assign cnt_sum = {1'b0, cnt_b} + 6'(DATA_W);

`ifdef SCRAMBLER_SERVICE_CHECK_EN
  logic svc_acc_q, svc_acc_d;
  logic service_err_q, service_err_d;
`endif

  always_comb begin
    s_d          = s_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    seed_out_d   = seed_out_q;
    seed_valid_d = seed_valid_q;
`ifdef SCRAMBLER_SERVICE_CHECK_EN
    svc_acc_d     = svc_acc_q;
    service_err_d = 1'b0;
`endif
    if (enable) begin
      s_d          = s_b;
      cnt_d        = cnt_b;
      mode_d       = mode_b;
      seed_out_d   = seed_out_b;
      seed_valid_d = seed_valid_b;
`ifdef SCRAMBLER_SERVICE_CHECK_EN
      if (start) svc_acc_d = 1'b0;
`endif
      if (in_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = out_vec;
        s_d         = chain_s[DATA_W];
        cnt_d       = (cnt_sum >= 6'(SERVICE_LEN)) ? CNT_W'(SERVICE_LEN) : cnt_sum[CNT_W-1:0];
        for (int i = 0; i < DATA_W; i++) begin
          if (mode_b == MODE_DESCRAMBLE && bit_cnt_w[i] == 6'(SEED_BITS-1)) begin
            seed_out_d   = chain_s[i+1];
            seed_valid_d = 1'b1;
          end
`ifdef SCRAMBLER_SERVICE_CHECK_EN
          if (mode_b == MODE_DESCRAMBLE && bit_cnt_w[i] >= 6'(SEED_BITS) &&
              bit_cnt_w[i] <= 6'(SERVICE_LEN-1))
            svc_acc_d = svc_acc_d | out_bit[i];
          if (mode_b == MODE_DESCRAMBLE && bit_cnt_w[i] == 6'(SERVICE_LEN-1))
            service_err_d = svc_acc_d;
`endif
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s_q          <= '0;
      cnt_q        <= '0;
      mode_q       <= MODE_DESCRAMBLE;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      seed_out_q   <= '0;
      seed_valid_q <= 1'b0;
    end else begin
      s_q          <= s_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      seed_out_q   <= seed_out_d;
      seed_valid_q <= seed_valid_d;
    end
  end

`ifdef SCRAMBLER_SERVICE_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      svc_acc_q     <= 1'b0;
      service_err_q <= 1'b0;
    end else begin
      svc_acc_q     <= svc_acc_d;
      service_err_q <= service_err_d;
    end
  end
  assign service_err = service_err_q;
`else
  assign service_err = 1'b0;
`endif

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign seed_out   = seed_out_q;
  assign seed_valid = seed_valid_q;
endmodule

// File: doc/scramble_par.md
# scramble_par

Parametrised 802.11 scrambler/descrambler: x^7+x^4+1 LFSR processing DATA_W bits per beat. Runtime-selectable mode: descramble with seed recovery from the first 7 received bits, or scramble from a supplied seed. Sits between the deinterleave/Viterbi output and the SERVICE/PSDU parser on RX, and before the encoder on TX. Reports the recovered seed and, optionally, SERVICE reserved-bit errors.

## Interface
- DATA_W, 1: bits per beat, 1..8. Bit 0 is the earliest bit in time.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- enable  in  1  global qualifier; low freezes all state and forces out_valid=0
- start  in  1  one-cycle pulse that begins a new frame
- mode  in  1  0=descramble, 1=scramble; sampled only on start
- seed_in  in  7  scramble seed, sampled on start when mode=1
- in_data  in  DATA_W  input bits
- in_valid  in  1  input beat strobe
- out_data  out  DATA_W  processed bits, same ordering as input
- out_valid  out  1  output beat strobe
- seed_out  out  7  recovered or loaded seed
- seed_valid  out  1  level; high once seed_out is final for the current frame
- service_err  out  1  one-cycle pulse when SERVICE[15:7] is nonzero

## Operation
- LFSR state s[6:0]. Per bit: fb = s[6]^s[3]; out = fb^in; s <= {s[5:0], fb}.
- A beat is unrolled as DATA_W sequential bit steps within one cycle; bit i sees the state produced by bit i-1.
- Frame bit counter cnt (5 bits) saturates at 16 and counts bits processed since start or reset.
- Reset leaves the block in descramble mode with a frame implicitly started: cnt=0, s=0.
- Descramble, bits with cnt<7:
  - load s[6-cnt] <= in; the output bit is 0, which is the defined SERVICE[6:0] value, so beats stay 1:1.
  - The bit that completes the seed (cnt=6) sets seed_valid and seed_out = the assembled s.
  - Remaining bits in the same beat are descrambled with that state.
- Descramble, bits with cnt>=7: normal step.
- Scramble: start loads s=seed_in and sets seed_out=seed_in and seed_valid=1. Every bit is a normal step.
- start with in_valid in the same cycle: start applies first, and the beat is processed as the first beat of the new frame.
- start during a frame aborts it: cnt=0, seed_valid=0 (descramble), s cleared (descramble) or loaded (scramble).
- A recovered all-zero seed is not special: output equals input from then on.

## Timing
- Latency: 1 cycle, in_valid to out_valid. Throughput: one beat per cycle, no backpressure.
- Reset values: out_data=0, out_valid=0, seed_out=0, seed_valid=0, service_err=0.
- out_valid = registered (enable & in_valid). If enable is low, the beat is dropped and no state changes.
- seed_valid rises in the same cycle as out_valid for the beat containing bit 6. In scramble mode it rises the cycle after start.
- service_err pulses with the out_valid of the beat containing bit 15.

## Configuration
- SCRAMBLER_SERVICE_CHECK_EN defined:
  - In descramble mode, output bits 7..15 are ORed into a sticky check.
  - service_err=1 for one cycle on the beat containing bit 15 if any of those bits was 1.
- Undefined: service_err tied 0 and no check logic is built.
- Scramble mode never asserts service_err.

## Structure
- Package scrambler_pkg holds:
  - LFSR_LEN=7, TAP_HI=6, TAP_LO=3, SEED_BITS=7, SERVICE_LEN=16
  - mode enum MODE_DESCRAMBLE=0, MODE_SCRAMBLE=1
- Sub-module scrambler_step: combinational single-bit step with inputs state, in, init_phase, init_idx and outputs next state and out. It is instantiated DATA_W times in a generate chain.

## Test plan
- DATA_W=8, scramble, seed_in=7'h7F, in_data=0x00 x2 -> out_data 0x70 then 0x4F (sequence 00001110 11110010); seed_out=7'h7F.
- DATA_W=8, descramble, feed those two beats -> out_data 0x00, 0x00; seed_out=7'h07 with seed_valid on beat 1; service_err=0.
- DATA_W=1, descramble, bitstream from scramble(seed 7'h5D, 64 random bits) -> 7 zero bits, then the exact original bits; seed_valid after bit 6.
- DATA_W=3, start+in_valid same cycle, mid-frame start, and enable toggled low mid-beat -> boundary seed split 3/3/1 handled; dropped beats produce no output and no state change; the restarted frame recovers its seed afresh.
- Macro defined, descramble with SERVICE bit 9 set -> single service_err pulse aligned with the beat containing bit 15. Macro undefined -> service_err stays 0.
- reset asserted mid-frame during scramble -> all outputs 0 next cycle; the following frame descrambles with no start pulse.
